// File: rtl/demux_pkg.sv
// Shared definitions for the 32-bit 1:2 stream demultiplexer.
// Holds default widths, select encodings and the holding-stage state type.
package demux_pkg;

    localparam int WIDTH_DEFAULT = 32;
    localparam int CNT_W_DEFAULT = 8;

    localparam logic SEL_OUT0 = 1'b0;
    localparam logic SEL_OUT1 = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } hold_state_e;

endpackage

// File: rtl/stream_hold_reg.sv
// One-entry registered valid/ready holding stage with a wrapping
// delivery counter; valid and data are driven straight from flops.
module stream_hold_reg
    import demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [CNT_W-1:0] o_cnt
);

    hold_state_e      r_state;
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [CNT_W-1:0] r_cnt;
    logic             w_deliver;

    assign w_deliver = r_valid & i_ready;

    // A load only arrives when the stage is empty or draining this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_EMPTY;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_deliver) begin
                r_cnt <= r_cnt + 1'b1;
            end
            unique case (r_state)
                ST_EMPTY: begin
                    if (i_load) begin
                        r_state <= ST_FULL;
                        r_valid <= 1'b1;
                        r_data  <= i_data;
                    end
                end
                ST_FULL: begin
                    if (i_load) begin
                        r_data <= i_data;
                    end else if (i_ready) begin
                        r_state <= ST_EMPTY;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_EMPTY;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_cnt   = r_cnt;

endmodule

// File: rtl/demux32_stream.sv
// Routes one valid/ready stream to one of two registered output stages,
// chosen per word by in_sel; only the selected sink can stall the input.
module demux32_stream
    import demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    logic w_sel0;
    logic w_sel1;
    logic w_room0;
    logic w_room1;
    logic w_accept;
    logic w_load0;
    logic w_load1;

    assign w_sel0  = (in_sel == SEL_OUT0);
    assign w_sel1  = (in_sel == SEL_OUT1);
    assign w_room0 = ~out0_valid | out0_ready;
    assign w_room1 = ~out1_valid | out1_ready;

    assign in_ready = ~reset & ((w_sel0 & w_room0) | (w_sel1 & w_room1));
    assign w_accept = in_valid & in_ready;
    assign w_load0  = w_accept & w_sel0;
    assign w_load1  = w_accept & w_sel1;

    stream_hold_reg #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_hold0 (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load0),
        .i_data  (in_data),
        .i_ready (out0_ready),
        .o_valid (out0_valid),
        .o_data  (out0_data),
        .o_cnt   (cnt0)
    );

    stream_hold_reg #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_hold1 (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load1),
        .i_data  (in_data),
        .i_ready (out1_ready),
        .o_valid (out1_valid),
        .o_data  (out1_data),
        .o_cnt   (cnt1)
    );

endmodule
